// File: rtl/song_sequencer_pkg.sv
// Shared audio package for the beat/tick scheduler.
// Holds the 12-bit note-row layout, the sequencer state enum and the
// default song timing constants used by song_sequencer.
package song_sequencer_pkg;

  localparam int unsigned TICKS_PER_BEAT_DEF = 6;
  localparam int unsigned SONG_LEN_DEF       = 288;
  localparam int unsigned POS_W_DEF          = 9;

  // Note-row layout, MSB first:
  // {mel_trig, mel_oct[1:0], mel_note[2:0], bass_trig, bass_oct[1:0], bass_note[2:0]}
  localparam int unsigned ROW_W          = 12;
  localparam int unsigned MEL_TRIG_BIT   = 11;
  localparam int unsigned MEL_OCT_LSB    = 9;
  localparam int unsigned MEL_NOTE_LSB   = 6;
  localparam int unsigned BASS_TRIG_BIT  = 5;
  localparam int unsigned BASS_OCT_LSB   = 3;
  localparam int unsigned BASS_NOTE_LSB  = 0;
  localparam int unsigned OCT_W          = 2;
  localparam int unsigned NOTE_W         = 3;

  typedef struct packed {
    logic              mel_trig;
    logic [OCT_W-1:0]  mel_oct;
    logic [NOTE_W-1:0] mel_note;
    logic              bass_trig;
    logic [OCT_W-1:0]  bass_oct;
    logic [NOTE_W-1:0] bass_note;
  } note_row_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } seq_state_e;

endpackage

// File: rtl/song_sequencer.sv
// Beat/tick scheduler for the two-voice square-wave engine.
// Counts frame ticks into beats, steps the song position (wrapping at
// SONG_LEN), fetches each new note row from the shared note ROM over a
// req/ack handshake and drives the voice note registers, trigger pulses
// and envelope-decay strobes.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   frame_tick            one-cycle start-of-frame pulse
//   run                   level, 0 = paused
//   restart               one-cycle pulse, next beat plays row 0
//   rom_req/rom_addr      note-ROM read request and row address
//   rom_ack/rom_data      note-ROM data strobe and 12-bit row
//   mel_*/bass_*          current voice notes/octaves and trigger pulses
//   decay                 one-cycle envelope-decay strobe (non-beat ticks)
//   songpos               current song row
//   overrun               sticky, a tick arrived during a fetch
//
// state | meaning
// IDLE  | counting ticks, no fetch outstanding
// FETCH | rom_req held high waiting for rom_ack
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = TICKS_PER_BEAT_DEF,
  parameter int unsigned SONG_LEN       = SONG_LEN_DEF,
  parameter int unsigned POS_W          = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             run,
  input  logic             restart,
  output logic             rom_req,
  output logic [POS_W-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [ROW_W-1:0] rom_data,
  output logic [2:0]       mel_note,
  output logic [1:0]       mel_oct,
  output logic [2:0]       bass_note,
  output logic [1:0]       bass_oct,
  output logic             mel_trig,
  output logic             bass_trig,
  output logic             decay,
  output logic [POS_W-1:0] songpos,
  output logic             overrun
);

  localparam int unsigned CTR_W = 4;
  localparam logic [CTR_W-1:0] CTR_BEAT    = CTR_W'(TICKS_PER_BEAT);
  localparam logic [CTR_W-1:0] CTR_PRELOAD = CTR_W'(TICKS_PER_BEAT - 1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(SONG_LEN - 1);

  seq_state_e        state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d, ctr_next;
  logic [POS_W-1:0]  songpos_q, songpos_d;
  logic [POS_W-1:0]  rom_addr_q, rom_addr_d;
  logic              rom_req_q, rom_req_d;
  logic              discard_q, discard_d;
  logic [2:0]        mel_note_q, mel_note_d, bass_note_q, bass_note_d;
  logic [1:0]        mel_oct_q, mel_oct_d, bass_oct_q, bass_oct_d;
  logic              mel_trig_q, mel_trig_d, bass_trig_q, bass_trig_d;
  logic              decay_q, decay_d;
  logic              overrun_q, overrun_d;
  note_row_t         row;

  assign row      = note_row_t'(rom_data);
  assign ctr_next = ctr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    songpos_d   = songpos_q;
    rom_addr_d  = rom_addr_q;
    rom_req_d   = rom_req_q;
    discard_d   = discard_q;
    mel_note_d  = mel_note_q;
    mel_oct_d   = mel_oct_q;
    bass_note_d = bass_note_q;
    bass_oct_d  = bass_oct_q;
    mel_trig_d  = 1'b0;
    bass_trig_d = 1'b0;
    decay_d     = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (frame_tick && run && !restart) begin
          if (ctr_next == CTR_BEAT) begin
            ctr_d      = '0;
            songpos_d  = (songpos_q == POS_LAST) ? '0 : songpos_q + 1'b1;
            rom_addr_d = (songpos_q == POS_LAST) ? '0 : songpos_q + 1'b1;
            rom_req_d  = 1'b1;
            state_d    = FETCH;
          end else begin
            ctr_d   = ctr_next;
            decay_d = 1'b1;
          end
        end
      end
      FETCH: begin
        // A tick cannot be serviced while the ROM is busy; record the loss.
        if (frame_tick && !restart) overrun_d = 1'b1;
        if (rom_ack) begin
          state_d   = IDLE;
          rom_req_d = 1'b0;
          discard_d = 1'b0;
          // Rows fetched before a restart belong to the old song position.
          if (!discard_q && !restart) begin
            mel_note_d  = row.mel_note;
            mel_oct_d   = row.mel_oct;
            bass_note_d = row.bass_note;
            bass_oct_d  = row.bass_oct;
            mel_trig_d  = row.mel_trig;
            bass_trig_d = row.bass_trig;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Preloading the counter makes the very next accepted tick a beat to row 0.
    if (restart) begin
      songpos_d = POS_LAST;
      ctr_d     = CTR_PRELOAD;
      overrun_d = 1'b0;
      if (state_q == FETCH && !rom_ack) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      songpos_q   <= POS_LAST;
      rom_addr_q  <= '0;
      rom_req_q   <= 1'b0;
      discard_q   <= 1'b0;
      mel_note_q  <= '0;
      mel_oct_q   <= '0;
      bass_note_q <= '0;
      bass_oct_q  <= '0;
      mel_trig_q  <= 1'b0;
      bass_trig_q <= 1'b0;
      decay_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      songpos_q   <= songpos_d;
      rom_addr_q  <= rom_addr_d;
      rom_req_q   <= rom_req_d;
      discard_q   <= discard_d;
      mel_note_q  <= mel_note_d;
      mel_oct_q   <= mel_oct_d;
      bass_note_q <= bass_note_d;
      bass_oct_q  <= bass_oct_d;
      mel_trig_q  <= mel_trig_d;
      bass_trig_q <= bass_trig_d;
      decay_q     <= decay_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rom_req   = rom_req_q;
  assign rom_addr  = rom_addr_q;
  assign mel_note  = mel_note_q;
  assign mel_oct   = mel_oct_q;
  assign bass_note = bass_note_q;
  assign bass_oct  = bass_oct_q;
  assign mel_trig  = mel_trig_q;
  assign bass_trig = bass_trig_q;
  assign decay     = decay_q;
  assign songpos   = songpos_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: scripted scenarios plus a random
// phase, all compared every cycle against a behavioural song model.
module tb_song_sequencer;

  localparam int TPB = 6;
  localparam int SL  = 288;
  localparam int PW  = 9;

  logic          clk = 1'b0;
  logic          rst_n, frame_tick, run, restart, rom_ack;
  logic [11:0]   rom_data;
  logic          rom_req, mel_trig, bass_trig, decay, overrun;
  logic [PW-1:0] rom_addr, songpos;
  logic [2:0]    mel_note, bass_note;
  logic [1:0]    mel_oct, bass_oct;

  song_sequencer #(.TICKS_PER_BEAT(TPB), .SONG_LEN(SL), .POS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
    .restart(restart), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .mel_note(mel_note),
    .mel_oct(mel_oct), .bass_note(bass_note), .bass_oct(bass_oct),
    .mel_trig(mel_trig), .bass_trig(bass_trig), .decay(decay),
    .songpos(songpos), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- ROM responder ----------------
  logic [11:0] rom_mem [SL];
  int ack_delay = 1;
  int wait_cnt = 0;
  bit random_delay = 0;
  bit spurious_en = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rom_ack  = 1'b0;
      wait_cnt = 0;
    end else if (rom_req) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        rom_ack  = 1'b1;
        rom_data = rom_mem[rom_addr];
      end else begin
        rom_ack  = 1'b0;
        rom_data = 12'($urandom);
      end
    end else begin
      wait_cnt = 0;
      if (random_delay) ack_delay = $urandom_range(1, 6);
      rom_ack  = spurious_en && ($urandom_range(0, 3) == 0);
      rom_data = 12'($urandom);
    end
  end

  // ---------------- behavioural model ----------------
  int m_pos, m_cnt, m_addr;
  bit m_fetch, m_disc, m_ovr;
  int m_mn, m_mo, m_bn, m_bo;
  bit e_decay, e_mt, e_bt;
  bit s_ft, s_run, s_rs, s_ack, was_fetch;
  int s_data;

  int n_decay = 0, n_req = 0, n_trig = 0, last_req_addr = -1;
  bit req_prev = 0, wrap_seen = 0;

  always @(posedge clk) begin
    s_ft = frame_tick; s_run = run; s_rs = restart; s_ack = rom_ack;
    s_data = int'(rom_data);
    e_decay = 0; e_mt = 0; e_bt = 0;
    if (!rst_n) begin
      m_pos = SL - 1; m_cnt = 0; m_addr = 0;
      m_fetch = 0; m_disc = 0; m_ovr = 0;
      m_mn = 0; m_mo = 0; m_bn = 0; m_bo = 0;
    end else begin
      was_fetch = m_fetch;
      if (was_fetch && s_ack) begin
        if (!m_disc && !s_rs) begin
          m_mn = (s_data / 64) % 8;
          m_mo = (s_data / 512) % 4;
          e_mt = (s_data / 2048) % 2;
          m_bn = s_data % 8;
          m_bo = (s_data / 8) % 4;
          e_bt = (s_data / 32) % 2;
        end
        m_fetch = 0;
        m_disc = 0;
      end
      if (s_rs) begin
        m_pos = SL - 1; m_cnt = TPB - 1; m_ovr = 0;
        if (m_fetch) m_disc = 1;
      end else if (s_ft) begin
        if (was_fetch) m_ovr = 1;
        else if (s_run) begin
          if (m_cnt + 1 == TPB) begin
            m_cnt = 0;
            m_pos = (m_pos + 1) % SL;
            m_addr = m_pos;
            m_fetch = 1;
          end else begin
            m_cnt++;
            e_decay = 1;
          end
        end
      end
    end
    #1;
    chk("songpos", songpos, m_pos);
    chk("rom_req", rom_req, m_fetch);
    if (m_fetch) chk("rom_addr", rom_addr, m_addr);
    chk("mel_note", mel_note, m_mn);
    chk("mel_oct", mel_oct, m_mo);
    chk("bass_note", bass_note, m_bn);
    chk("bass_oct", bass_oct, m_bo);
    chk("mel_trig", mel_trig, e_mt);
    chk("bass_trig", bass_trig, e_bt);
    chk("decay", decay, e_decay);
    chk("overrun", overrun, m_ovr);
    if (decay) n_decay++;
    if (mel_trig || bass_trig) n_trig++;
    if (rom_req && !req_prev) begin
      n_req++;
      if (rom_addr == 0 && last_req_addr == SL - 1) wrap_seen = 1;
      last_req_addr = int'(rom_addr);
    end
    req_prev = rom_req;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic wait_req_low(input int lim);
    int k = 0;
    while (rom_req && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("req_timeout", rom_req, 0);
  endtask

  int d0, r0, t0, row1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; frame_tick = 0; run = 0; restart = 0;
    rom_ack = 0; rom_data = 0;
    for (int i = 0; i < SL; i++) rom_mem[i] = 12'($urandom);
    rom_mem[0] = 12'h8A1;
    cyc(3);
    chk("rst_songpos", songpos, 287);
    chk("rst_req", rom_req, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mel_note", mel_note, 0);
    rst_n = 1; run = 1;
    cyc(2);

    // first beat after reset
    d0 = n_decay;
    repeat (5) begin tick(); cyc(2); end
    chk("five_decays", n_decay - d0, 5);
    chk("no_req_early", rom_req, 0);
    tick();
    chk("beat_req", rom_req, 1);
    chk("beat_addr", rom_addr, 0);
    cyc(1);
    chk("row0_mel_trig", mel_trig, 1);
    chk("row0_mel_oct", mel_oct, 0);
    chk("row0_mel_note", mel_note, 2);
    chk("row0_bass_oct", bass_oct, 0);
    chk("row0_bass_note", bass_note, 1);
    chk("row0_bass_trig", bass_trig, 1);
    chk("row0_req_drop", rom_req, 0);
    cyc(2);

    // full song wrap
    wrap_seen = 0;
    repeat (SL * TPB) begin tick(); cyc($urandom_range(1, 4)); end
    chk("wrap_seen", wrap_seen, 1);
    chk("wrap_pos", songpos, 0);

    // slow ROM with a tick mid-fetch
    ack_delay = 100;
    repeat (5) begin tick(); cyc(1); end
    tick();
    chk("slow_req", rom_req, 1);
    d0 = n_decay;
    cyc(48);
    tick();
    chk("slow_overrun", overrun, 1);
    chk("slow_songpos", songpos, 1);
    chk("slow_no_decay", n_decay - d0, 0);
    wait_req_low(200);
    ack_delay = 1;
    cyc(2);

    // paused
    run = 0;
    d0 = n_decay; r0 = n_req;
    repeat (10) begin tick(); cyc(1); end
    chk("pause_decay", n_decay - d0, 0);
    chk("pause_req", n_req - r0, 0);
    chk("pause_songpos", songpos, 1);
    run = 1;
    tick();
    chk("resume_decay", decay, 1);
    cyc(1);

    // restart during fetch
    ack_delay = 3;
    repeat (4) begin tick(); cyc(1); end
    tick();
    chk("rs_fetch_req", rom_req, 1);
    t0 = n_trig;
    row1 = int'(rom_mem[1]);
    restart = 1;
    cyc(1);
    restart = 0;
    wait_req_low(20);
    cyc(1);
    chk("rs_no_trig", n_trig - t0, 0);
    chk("rs_mel_note", mel_note, (row1 / 64) % 8);
    chk("rs_bass_note", bass_note, row1 % 8);
    chk("rs_overrun", overrun, 0);
    tick();
    chk("rs_next_req", rom_req, 1);
    chk("rs_next_addr", rom_addr, 0);
    cyc(5);

    // restart and tick together
    @(negedge clk); frame_tick = 1; restart = 1;
    @(negedge clk); frame_tick = 0; restart = 0;
    chk("rs_tick_decay", decay, 0);
    chk("rs_tick_req", rom_req, 0);
    chk("rs_tick_overrun", overrun, 0);
    ack_delay = 1;
    tick();
    chk("rs_tick_beat_req", rom_req, 1);
    chk("rs_tick_beat_addr", rom_addr, 0);
    cyc(3);

    // random traffic
    random_delay = 1; spurious_en = 1;
    repeat (4000) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 3) == 0);
      run        = ($urandom_range(0, 9) != 0);
      restart    = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    frame_tick = 0; restart = 0; run = 1;
    random_delay = 0; spurious_en = 0; ack_delay = 1;
    wait_req_low(100);
    cyc(2);

    // async reset with a fetch outstanding
    ack_delay = 50;
    @(negedge clk) restart = 1;
    @(negedge clk) restart = 0;
    tick();
    chk("ar_req", rom_req, 1);
    #2 rst_n = 0;
    #1 chk("ar_req_drop", rom_req, 0);
    cyc(2);
    rst_n = 1;
    ack_delay = 1;
    cyc(3);
    chk("ar_songpos", songpos, 287);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
